sprite_layer_addr_gen: RTL and testbench

//  Multi-sprite, animated, pipelined successor of the single-sprite address generator.

---
 rtl/sprite_layer_addr_gen.sv | 154 +++++++++++++++
 tb/tb_sprite_layer_addr_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_addr_gen.sv
// sprite_layer_addr_gen
//   Multi-sprite ROM address generator with per-sprite animation frames.
//   Per pixel: window test for every sprite (S1), lowest-index priority
//   select (S2), giving {frame, row, col} and the winning sprite id two
//   cycles after the pixel enters.
//   Optional feature macro: SPRITE_FLIP_EN (adds flip_x horizontal mirror).
module sprite_layer_addr_gen #(
  parameter  int NSPR      = 4,
  parameter  int CW        = 11,
  parameter  int LOG_W     = 6,
  parameter  int LOG_H     = 6,
  parameter  int LOG_F     = 2,
  parameter  int FRAME_DIV = 8,
  localparam int AW        = LOG_F + LOG_H + LOG_W,
  localparam int IW        = (NSPR > 1) ? $clog2(NSPR) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_valid,
  input  logic [CW-1:0]          pixelx,
  input  logic [CW-1:0]          pixely,
  input  logic [NSPR*CW-1:0]     posx,
  input  logic [NSPR*CW-1:0]     posy,
  input  logic [NSPR-1:0]        spr_en,
  input  logic [NSPR-1:0]        anim_en,
  input  logic                   frame_tick,
`ifdef SPRITE_FLIP_EN
  input  logic [NSPR-1:0]        flip_x,
`endif
  output logic                   out_valid,
  output logic [AW-1:0]          address,
  output logic [IW-1:0]          sprite_id,
  output logic                   in_bounds,
  output logic [NSPR*LOG_F-1:0]  frame_dbg
);

  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

  // Animation state
  logic [DW-1:0]    div_cnt;
  logic [LOG_F-1:0] frame [NSPR];
  logic             anim_step;

  // S1 combinational differences
  logic [CW:0]      dx_c  [NSPR];
  logic [CW:0]      dy_c  [NSPR];
  logic [NSPR-1:0]  hit_c;
  logic [LOG_W-1:0] col_c [NSPR];

  // S1 registers
  logic             v1;
  logic [NSPR-1:0]  hit1;
  logic [LOG_W-1:0] col1 [NSPR];
  logic [LOG_H-1:0] row1 [NSPR];
  logic [LOG_F-1:0] frm1 [NSPR];

  // S2 priority-select result
  logic             found_c;
  logic [AW-1:0]    win_addr_c;
  logic [IW-1:0]    win_id_c;

  // Divider wrap: the tick that completes a FRAME_DIV group advances frames
  always_comb begin
    anim_step = frame_tick && (div_cnt == DIV_LAST);
  end

  // Tick divider and per-sprite frame counters (frames wrap naturally)
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      for (int unsigned i = 0; i < NSPR; i++) frame[i] <= '0;
    end else if (frame_tick) begin
      if (anim_step) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
      for (int unsigned i = 0; i < NSPR; i++)
        if (anim_step && anim_en[i]) frame[i] <= frame[i] + 1'b1;
    end
  end

  // Debug view of the frame counters, packed like posx
  always_comb begin
    frame_dbg = '0;
    for (int unsigned i = 0; i < NSPR; i++)
      frame_dbg[i*LOG_F +: LOG_F] = frame[i];
  end

  // Window test: sign-extended CW+1 differences; a hit needs every bit at or
  // above the size bit (sign included) clear, i.e. 0 <= d < 2**LOG
  always_comb begin
    hit_c = '0;
    for (int unsigned i = 0; i < NSPR; i++) begin
      dx_c[i] = {pixelx[CW-1], pixelx} - {posx[i*CW + CW - 1], posx[i*CW +: CW]};
      dy_c[i] = {pixely[CW-1], pixely} - {posy[i*CW + CW - 1], posy[i*CW +: CW]};
      hit_c[i] = spr_en[i] && !(|dx_c[i][CW:LOG_W]) && !(|dy_c[i][CW:LOG_H]);
`ifdef SPRITE_FLIP_EN
      col_c[i] = dx_c[i][LOG_W-1:0] ^ {LOG_W{flip_x[i]}};
`else
      col_c[i] = dx_c[i][LOG_W-1:0];
`endif
    end
  end

  // S1 register stage; frame is sampled before any same-cycle tick update
  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      hit1 <= '0;
      for (int unsigned i = 0; i < NSPR; i++) begin
        col1[i] <= '0;
        row1[i] <= '0;
        frm1[i] <= '0;
      end
    end else begin
      v1   <= pix_valid;
      hit1 <= hit_c;
      for (int unsigned i = 0; i < NSPR; i++) begin
        col1[i] <= col_c[i];
        row1[i] <= dy_c[i][LOG_H-1:0];
        frm1[i] <= frame[i];
      end
    end
  end

  // Lowest-index hit wins
  always_comb begin
    found_c    = 1'b0;
    win_addr_c = '0;
    win_id_c   = '0;
    for (int unsigned i = 0; i < NSPR; i++) begin
      if (!found_c && hit1[i]) begin
        found_c    = 1'b1;
        win_addr_c = {frm1[i], row1[i], col1[i]};
        win_id_c   = IW'(i);
      end
    end
  end

  // S2 output register; all outputs forced to zero when not valid
  always_ff @(posedge clk) begin
    if (reset || !v1) begin
      out_valid <= 1'b0;
      address   <= '0;
      sprite_id <= '0;
      in_bounds <= 1'b0;
    end else begin
      out_valid <= 1'b1;
      address   <= win_addr_c;
      sprite_id <= win_id_c;
      in_bounds <= found_c;
    end
  end

endmodule

// File: tb/tb_sprite_layer_addr_gen.sv
// tb_sprite_layer_addr_gen
//   Table-driven vectors plus hand sequences; expected results queued at
//   drive time and compared when the delayed valid comes out.
module tb_sprite_layer_addr_gen;

  localparam int NSPR  = 4;
  localparam int CW    = 11;
  localparam int LOG_F = 2;
  localparam int AW    = 14;
  localparam int IW    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  pix_valid;
  logic [CW-1:0]         pixelx, pixely;
  logic [NSPR*CW-1:0]    posx, posy;
  logic [NSPR-1:0]       spr_en, anim_en;
  logic                  frame_tick;
`ifdef SPRITE_FLIP_EN
  logic [NSPR-1:0]       flip_x;
`endif
  logic                  out_valid;
  logic [AW-1:0]         address;
  logic [IW-1:0]         sprite_id;
  logic                  in_bounds;
  logic [NSPR*LOG_F-1:0] frame_dbg;

  sprite_layer_addr_gen #(.NSPR(NSPR), .CW(CW), .LOG_W(6), .LOG_H(6),
                          .LOG_F(LOG_F), .FRAME_DIV(8)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid),
    .pixelx(pixelx), .pixely(pixely), .posx(posx), .posy(posy),
    .spr_en(spr_en), .anim_en(anim_en), .frame_tick(frame_tick),
`ifdef SPRITE_FLIP_EN
    .flip_x(flip_x),
`endif
    .out_valid(out_valid), .address(address), .sprite_id(sprite_id),
    .in_bounds(in_bounds), .frame_dbg(frame_dbg)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; bit inb; int id; int addr; } vec_t;
  typedef struct { bit inb; int id; int addr; string nm; } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  logic pv1 = 1'b0, pv2 = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference valid delay line
  always @(posedge clk) begin
    if (reset) begin
      pv1 <= 1'b0;
      pv2 <= 1'b0;
    end else begin
      pv1 <= pix_valid;
      pv2 <= pv1;
    end
  end

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", int'(out_valid), int'(pv2));
      if (pv2) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got output with no expected entry (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.nm, "_inb"},  int'(in_bounds), int'(e.inb));
          chk({e.nm, "_id"},   int'(sprite_id), e.id);
          chk({e.nm, "_addr"}, int'(address),   e.addr);
        end
      end else begin
        chk("idle_addr", int'(address),   0);
        chk("idle_id",   int'(sprite_id), 0);
        chk("idle_inb",  int'(in_bounds), 0);
      end
    end
  end

  task automatic set_pos(input int i, input int x, input int y);
    posx[i*CW +: CW] = CW'(x);
    posy[i*CW +: CW] = CW'(y);
  endtask

  task automatic send(input int x, input int y, input bit tk, input bit inb,
                      input int id, input int addr, input string nm);
    exp_t e;
    pixelx     = CW'(x);
    pixely     = CW'(y);
    pix_valid  = 1'b1;
    frame_tick = tk;
    e.inb = inb; e.id = id; e.addr = addr; e.nm = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    pix_valid  = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
  endtask

  vec_t vecs[10];

  initial begin
    // sprite0 (100,50), sprite1/2 (10,10), sprite3 (-20,-5), all enabled
    vecs[0] = '{100,  50, 1'b1, 0, 0};
    vecs[1] = '{163, 113, 1'b1, 0, 4095};
    vecs[2] = '{164,  50, 1'b0, 0, 0};
    vecs[3] = '{ 99,  50, 1'b0, 0, 0};
    vecs[4] = '{ 12,  15, 1'b1, 1, (5 << 6) | 2};
    vecs[5] = '{  0,   0, 1'b1, 3, (5 << 6) | 20};
    vecs[6] = '{-20,  -5, 1'b1, 3, 0};
    vecs[7] = '{-21,   0, 1'b0, 0, 0};
    vecs[8] = '{ 43,  58, 1'b1, 1, (48 << 6) | 33};
    vecs[9] = '{100, 114, 1'b0, 0, 0};

    reset = 1'b1; pix_valid = 1'b0; pixelx = '0; pixely = '0;
    posx = '0; posy = '0; spr_en = '0; anim_en = '0; frame_tick = 1'b0;
`ifdef SPRITE_FLIP_EN
    flip_x = '0;
`endif
    idle(3);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_addr",  int'(address),   0);
    chk("rst_id",    int'(sprite_id), 0);
    chk("rst_inb",   int'(in_bounds), 0);
    chk("rst_frame", int'(frame_dbg), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    set_pos(0, 100, 50); set_pos(1, 10, 10); set_pos(2, 10, 10); set_pos(3, -20, -5);
    spr_en = 4'b1111;
    for (int k = 0; k < 10; k++)
      send(vecs[k].x, vecs[k].y, 1'b0, vecs[k].inb, vecs[k].id, vecs[k].addr, "vec");
    idle(3);

    // Overlap priority, then only the higher-index sprite enabled
    spr_en = 4'b0110;
    send(12, 15, 1'b0, 1'b1, 1, (5 << 6) | 2, "ovl_lo");
    spr_en = 4'b0100;
    send(12, 15, 1'b0, 1'b1, 2, (5 << 6) | 2, "ovl_hi");
    idle(3);

    // Screen-edge aliasing: extreme positions never hit the visible line
    spr_en = 4'b0001;
    set_pos(0, 1023, 0);
    for (int x = 0; x < 640; x++) send(x, 0, 1'b0, 1'b0, 0, 0, "far_right");
    set_pos(0, -1024, 0);
    for (int x = 0; x < 640; x++) send(x, 0, 1'b0, 1'b0, 0, 0, "far_left");
    send(-1019, 0, 1'b0, 1'b1, 0, 5, "neg_edge");
    set_pos(0, 1000, 0);
    send(1023, 0, 1'b0, 1'b1, 0, 23, "pos_edge");
    idle(3);

    // Mid-stream reset flushes both stages
    set_pos(0, 100, 50);
    send(100, 50, 1'b0, 1'b1, 0, 0, "pre_rst0");
    send(101, 50, 1'b0, 1'b1, 0, 1, "pre_rst1");
    do_reset();
    idle(3);

    // Animation
    anim_en = 4'b0001;
    tick(7);
    chk("frame_7", int'(frame_dbg), 0);
    tick(1);
    chk("frame_8", int'(frame_dbg), 1);
    send(100, 50, 1'b0, 1'b1, 0, 1 << 12, "anim_f1");
    tick(7);
    // 16th tick coincident with a pixel: pixel sees the old frame
    send(100, 50, 1'b1, 1'b1, 0, 1 << 12, "tick_same");
    send(100, 50, 1'b0, 1'b1, 0, 2 << 12, "tick_next");
    chk("frame_16", int'(frame_dbg), 2);
    tick(16);
    chk("frame_32", int'(frame_dbg), 0);
    tick(8);
    anim_en = 4'b0000;
    tick(8);
    chk("frame_hold", int'(frame_dbg), 1);
    anim_en = 4'b0001;
    tick(5);
    do_reset();
    chk("frame_rst", int'(frame_dbg), 0);
    tick(7);
    chk("div_restart7", int'(frame_dbg), 0);
    tick(1);
    chk("div_restart8", int'(frame_dbg), 1);
    idle(3);

`ifdef SPRITE_FLIP_EN
    flip_x = 4'b0001;
    send(100, 50, 1'b0, 1'b1, 0, (1 << 12) | 63, "flip0");
    send(101, 50, 1'b0, 1'b1, 0, (1 << 12) | 62, "flip1");
    flip_x = 4'b0000;
    idle(3);
`endif

    // Streaming with random gaps: data must stay aligned to out_valid
    for (int k = 0; k < 48; k++) begin
      if ($urandom_range(0, 1) == 1)
        send(100 + k, 50, 1'b0, 1'b1, 0, (1 << 12) | k, "stream");
      else
        idle(1);
    end
    idle(4);
    chk("sb_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
